// File: rtl/clk_en_sched_m.sv
// Programmable-period clock enable / square-wave generator with run, period-aligned stop,
// single-step, and a req/ack divisor update that only lands on period boundaries.
module clk_en_sched_m #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             clk_100,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             div_wr,
  input  logic [CNT_W-1:0] div_in,
  output logic             div_busy,
  output logic             div_ack,
  output logic [CNT_W-1:0] cur_div,
  output logic             clk_en,
  output logic             clk_out,
  output logic [15:0]      period_cnt
);

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic [15:0]      period_cnt_q, period_cnt_d;

  logic active, boundary, apply;

  always_comb begin
    active   = (state_q != ST_STOP);
    boundary = active && (cnt_q == cur_div_q);
    // A stopped generator has no period in flight, so a pending divisor lands immediately.
    apply    = busy_q && (!active || boundary);

    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_div_d    = cur_div_q;
    pend_d       = pend_q;
    busy_d       = busy_q;
    period_cnt_d = period_cnt_q;

    unique case (state_q)
      ST_STOP: begin
        if (run)       state_d = ST_RUN;
        else if (step) state_d = ST_STEP;
      end
      ST_RUN:  if (boundary && !run) state_d = ST_STOP;
      ST_STEP: if (boundary) state_d = run ? ST_RUN : ST_STOP;
      default: state_d = ST_STOP;
    endcase

    if (!active || boundary) cnt_d = ONE;
    else                     cnt_d = cnt_q + ONE;

    if (boundary) period_cnt_d = period_cnt_q + 16'd1;

    // busy_q gates capture, so a write during the apply cycle is dropped.
    if (apply) begin
      cur_div_d = pend_q;
      busy_d    = 1'b0;
      cnt_d     = ONE;
    end else if (div_wr && !busy_q) begin
      pend_d = (div_in < MIN_DIV) ? MIN_DIV : div_in;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q      <= ST_STOP;
      cnt_q        <= ONE;
      cur_div_q    <= DEF_DIV;
      pend_q       <= DEF_DIV;
      busy_q       <= 1'b0;
      period_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_div_q    <= cur_div_d;
      pend_q       <= pend_d;
      busy_q       <= busy_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  assign div_busy   = busy_q;
  assign div_ack    = apply;
  assign cur_div    = cur_div_q;
  assign clk_en     = boundary;
  assign clk_out    = (cnt_q <= (cur_div_q >> 1));
  assign period_cnt = period_cnt_q;

endmodule

// File: tb/tb_clk_en_sched_m.sv
// Scoreboard bench for clk_en_sched_m: a period-level reference model pushes the expected
// per-cycle outputs, and a negedge monitor pops and compares them against the DUT.
module tb_clk_en_sched_m;
  localparam int CNT_W = 8;
  localparam int DEF   = 4;

  logic             clk_100 = 1'b0;
  logic             rst, run, step, div_wr;
  logic [CNT_W-1:0] div_in;
  logic             div_busy, div_ack, clk_en, clk_out;
  logic [CNT_W-1:0] cur_div;
  logic [15:0]      period_cnt;

  clk_en_sched_m #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk_100(clk_100), .rst(rst), .run(run), .step(step), .div_wr(div_wr), .div_in(div_in),
    .div_busy(div_busy), .div_ack(div_ack), .cur_div(cur_div), .clk_en(clk_en),
    .clk_out(clk_out), .period_cnt(period_cnt)
  );

  always #5 clk_100 = ~clk_100;

  typedef struct {
    logic        en, co, ack, busy;
    logic [7:0]  div;
    logic [15:0] pcnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  // Reference model: mode 0 = parked, 1 = free-running, 2 = one-shot period.
  int          m_mode, m_pos, m_n, m_pend;
  bit          m_busy;
  int unsigned m_periods;

  function automatic void m_reset();
    m_mode = 0; m_pos = 1; m_n = DEF; m_pend = 0; m_busy = 0; m_periods = 0;
  endfunction

  task automatic cyc(input bit r, input bit s, input bit w, input int d, input bit rs);
    exp_t e;
    bit   ticking, last;
    run = r; step = s; div_wr = w; div_in = 8'(d); rst = rs;
    ticking = (m_mode != 0);
    last    = ticking && (m_pos == m_n);
    e.en   = last;
    e.co   = (m_pos <= m_n / 2);
    e.ack  = m_busy && (!ticking || last);
    e.busy = m_busy;
    e.div  = 8'(m_n);
    e.pcnt = 16'(m_periods % 65536);
    sb.push_back(e);
    if (rs) m_reset();
    else begin
      if (e.ack) begin m_n = m_pend; m_busy = 0; end
      else if (w && !m_busy) begin m_pend = (d < 2) ? 2 : d; m_busy = 1; end
      if (last) m_periods++;
      case (m_mode)
        0: m_mode = r ? 1 : (s ? 2 : 0);
        1: m_mode = (last && !r) ? 0 : 1;
        default: m_mode = last ? (r ? 1 : 0) : 2;
      endcase
      m_pos = (!ticking || last || e.ack) ? 1 : m_pos + 1;
    end
    @(posedge clk_100); #1;
    cyc_no++;
  endtask

  always @(negedge clk_100) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (clk_en !== e.en || clk_out !== e.co || div_ack !== e.ack || div_busy !== e.busy ||
          cur_div !== e.div || period_cnt !== e.pcnt) begin
        errors++;
        $display("FAIL cycle_outputs @%0d: got en=%b out=%b ack=%b busy=%b div=%0d pcnt=%0d, want en=%b out=%b ack=%b busy=%b div=%0d pcnt=%0d",
                 cyc_no, clk_en, clk_out, div_ack, div_busy, cur_div, period_cnt,
                 e.en, e.co, e.ack, e.busy, e.div, e.pcnt);
      end
    end
  end

  initial begin
    bit r;
    run = 0; step = 0; div_wr = 0; div_in = '0; rst = 1;
    repeat (2) @(posedge clk_100);
    #1;
    m_reset();
    cyc(0, 0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    // free-run at the default divisor
    repeat (14) cyc(1, 0, 0, 0, 0);
    // divisor change requested mid-period, lands on the next boundary
    cyc(1, 0, 1, 6, 0);
    repeat (20) cyc(1, 0, 0, 0, 0);
    // back to 4, then stop mid-period
    cyc(1, 0, 1, 4, 0);
    repeat (11) cyc(1, 0, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0);
    // single step, then steps while running are ignored
    cyc(0, 1, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 0, 0);
    repeat (3) begin cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); end
    repeat (8) cyc(0, 0, 0, 0, 0);
    // clamp while stopped, second write dropped while busy
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 7, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    // pending divisor discarded by reset mid-period
    repeat (3) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 9, 0);
    cyc(1, 0, 0, 0, 1);
    repeat (12) cyc(1, 0, 0, 0, 0);
    // randomized traffic
    r = 1;
    for (int i = 0; i < 6000; i++) begin
      int d;
      if ($urandom_range(99) < 3) r = ~r;
      d = ($urandom_range(9) == 0) ? int'($urandom_range(255)) : int'($urandom_range(9));
      cyc(r, $urandom_range(99) < 5, $urandom_range(99) < 4, d, $urandom_range(999) < 3);
    end
    @(negedge clk_100);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
